// File: rtl/svc_rv_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Holds busy while a division is in flight and drops it in the cycle done pulses.
module svc_rv_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            done
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode for the IDLE launch
    logic            in_signed, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] a_abs, b_abs, special_val;

    // One restoring step
    logic [XLEN:0]   rem_shift;
    logic            q_bit;
    logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix;
    logic            op_signed;

    always_comb begin
        in_signed   = !op[0];
        a_neg       = in_signed && a[XLEN-1];
        b_neg       = in_signed && b[XLEN-1];
        a_abs       = a_neg ? ('0 - a) : a;
        b_abs       = b_neg ? ('0 - b) : b;
        div_zero    = (b == '0);
        ovf         = in_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        if (div_zero)
            special_val = op[1] ? a : '1;
        else
            special_val = op[1] ? '0 : a;

        // The shifted partial remainder can exceed XLEN bits; its top bit forces a subtract.
        rem_shift = {rem_q, quo_q[XLEN-1]};
        q_bit     = rem_shift[XLEN] || (rem_shift[XLEN-1:0] >= divisor_q);
        rem_step  = q_bit ? (rem_shift[XLEN-1:0] - divisor_q) : rem_shift[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], q_bit};
        op_signed = !op_q[0];
        quo_fix   = (op_signed && (sign_a_q ^ sign_b_q)) ? ('0 - quo_step) : quo_step;
        rem_fix   = (op_signed && sign_a_q) ? ('0 - rem_step) : rem_step;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && !kill) begin
                    busy      = 1'b1;
                    op_d      = op;
                    sign_a_d  = a_neg;
                    sign_b_d  = b_neg;
                    quo_d     = a_abs;
                    divisor_d = b_abs;
                    rem_d     = '0;
                    cnt_d     = CW'(XLEN - 1);
                    if (div_zero || ovf) begin
                        result_d = special_val;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                busy  = 1'b1;
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // en still belongs to the completing instruction here
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (kill) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            busy     = 1'b0;
            done     = 1'b0;
        end
        if (!rst_n) begin
            busy = 1'b0;
            done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule
